wave_sequencer: RTL and testbench

Upstream control stage for the LED wave generators. Debounces the two board push-buttons, runs a free-running step prescaler, and issues per-wave `start` and per-step `step` pulses plus a stable direction code to the wave stage. Waves are triggered manually or continuously in auto mode. Sits between the board I/O pins and the wave pattern stage.

---
 rtl/wave_pkg.sv | 11 +
 rtl/wave_sequencer_if.sv | 17 +
 rtl/btn_debounce.sv | 38 +++
 rtl/wave_sequencer.sv | 92 +++++++++
 tb/tb_wave_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wave_pkg.sv
// Shared types for the LED wave sequencer: direction codes, FSM states and the
// fixed wave length.
package wave_pkg;

  typedef enum logic [1:0] {WAVE_RIGHT, WAVE_LEFT, WAVE_UP, WAVE_DOWN} wave_dir_t;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_ARM, SEQ_RUN} seq_state_t;

  localparam int WAVE_STEPS = 7;

endpackage

// File: rtl/wave_sequencer_if.sv
// Button/mode inputs and the step/start/dir/busy bundle toward the wave stage.
interface wave_sequencer_if;
  import wave_pkg::*;

  logic      btn_dir_n;
  logic      btn_go_n;
  logic      auto_en;
  logic      step;
  logic      start;
  wave_dir_t dir;
  logic      busy;

  modport master (input  btn_dir_n, btn_go_n, auto_en,
                  output step, start, dir, busy);
  modport slave  (output btn_dir_n, btn_go_n, auto_en,
                  input  step, start, dir, busy);
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counter debounce and a one-cycle press pulse on a
// debounced high-to-low transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2, db, db_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      db    <= 1'b1;
      db_d  <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn_n;
      s2    <= s1;
      db_d  <= db;
      press <= db_d & ~db;
      // any sample matching the accepted level restarts the stability count
      if (s2 == db)             cnt <= '0;
      else if (cnt == CNT_MAX) begin
        db  <= s2;
        cnt <= '0;
      end else                  cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/wave_sequencer.sv
// Step prescaler and wave FSM: turns debounced button events and auto mode into
// start/step pulses with a per-wave stable direction.
module wave_sequencer #(
  parameter int STEP_DIV        = 13_500_000,
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic             clk,
  input  logic             rst,
  wave_sequencer_if.master wif
);
  import wave_pkg::*;

  localparam int            PW      = $clog2(STEP_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(STEP_DIV - 1);
  localparam logic [2:0]    IDX_END = 3'(WAVE_STEPS - 1);

  logic [PW-1:0] presc;
  logic          tick, go_ev, dir_ev;
  logic          wave_end, rearm, adv;
  seq_state_t    state;
  logic [2:0]    idx;
  logic          pending;
  logic [1:0]    sel;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
    .clk(clk), .rst(rst), .btn_n(wif.btn_dir_n), .press(dir_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go (
    .clk(clk), .rst(rst), .btn_n(wif.btn_go_n), .press(go_ev));

  // free-running: trigger timing never disturbs the step phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  assign tick     = (presc == PRE_MAX);
  assign wave_end = (state == SEQ_RUN) && tick && (idx == IDX_END);
  // a go event coinciding with the last step still queues the next wave
  assign rearm    = pending || wif.auto_en || go_ev;
  assign adv      = wave_end && wif.auto_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEQ_IDLE;
      idx       <= '0;
      pending   <= 1'b0;
      sel       <= '0;
      wif.step  <= 1'b0;
      wif.start <= 1'b0;
      wif.dir   <= WAVE_RIGHT;
      wif.busy  <= 1'b0;
    end else begin
      wif.step  <= 1'b0;
      wif.start <= 1'b0;
      sel       <= sel + 2'(dir_ev) + 2'(adv);
      case (state)
        SEQ_IDLE: if (go_ev || wif.auto_en) begin
          state    <= SEQ_ARM;
          wif.busy <= 1'b1;
        end
        SEQ_ARM: begin
          if (go_ev) pending <= 1'b1;
          if (tick) begin
            wif.step  <= 1'b1;
            wif.start <= 1'b1;
            wif.dir   <= wave_dir_t'(sel);
            idx       <= 3'd1;
            state     <= SEQ_RUN;
          end
        end
        SEQ_RUN: begin
          if (go_ev) pending <= 1'b1;
          if (tick) begin
            wif.step <= 1'b1;
            idx      <= idx + 1'b1;
            if (wave_end) begin
              if (rearm) begin
                state   <= SEQ_ARM;
                pending <= 1'b0;
              end else begin
                state    <= SEQ_IDLE;
                wif.busy <= 1'b0;
              end
            end
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wave_sequencer.sv
// Randomized and directed bench for wave_sequencer against a cycle model built
// from raw button history, a global step clock and wave bookkeeping.
module tb_wave_sequencer;
  import wave_pkg::*;

  localparam int SD = 4;
  localparam int D  = 3;
  localparam int N  = 50000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wave_sequencer_if wif();

  wave_sequencer #(.STEP_DIV(SD), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .wif(wif));

  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_step = 0, nstep = 0;
  int starts[$];
  int start_cyc[$];

  // model state: raw button history per clock edge, accepted levels, wave bookkeeping
  bit hgo[N], hdir[N], fgo[N], fdir[N];
  int e;
  bit dbg, dbd;
  int phase;        // 0 no wave, 1 waiting for step clock, 2 stepping
  int nsteps, msel, mdir, m_starts = 0;
  bit pend, mbusy, mstep, mstart;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit raw_at(bit is_dir, int i);
    if (i < 1) return 1'b1;
    return is_dir ? hdir[i] : hgo[i];
  endfunction

  task automatic model_reset();
    e = 0; dbg = 1; dbd = 1; phase = 0; nsteps = 0; pend = 0;
    msel = 0; mdir = 0; mbusy = 0; mstep = 0; mstart = 0;
  endtask

  task automatic model_step();
    bit fl, go_ev, dir_ev, tick, adv;
    e++;
    hgo[e]  = wif.btn_go_n;
    hdir[e] = wif.btn_dir_n;
    // accepted level flips once the last D synchronized samples all disagree with it
    fl = 1;
    for (int j = 0; j < D; j++) if (raw_at(0, e-2-j) == dbg) fl = 0;
    fgo[e] = fl && dbg;
    if (fl) dbg = !dbg;
    fl = 1;
    for (int j = 0; j < D; j++) if (raw_at(1, e-2-j) == dbd) fl = 0;
    fdir[e] = fl && dbd;
    if (fl) dbd = !dbd;
    go_ev  = (e >= 3) && fgo[e-2];
    dir_ev = (e >= 3) && fdir[e-2];
    tick   = (e % SD) == 0;
    mstep = 0; mstart = 0; adv = 0;
    case (phase)
      0: if (go_ev || wif.auto_en) begin phase = 1; mbusy = 1; end
      1: begin
        if (go_ev) pend = 1;
        if (tick) begin
          mstep = 1; mstart = 1; mdir = msel; nsteps = 1; phase = 2; m_starts++;
        end
      end
      default: begin
        if (go_ev) pend = 1;
        if (tick) begin
          mstep = 1;
          nsteps++;
          if (nsteps == WAVE_STEPS) begin
            if (pend || wif.auto_en) begin
              phase = 1; pend = 0; adv = wif.auto_en;
            end else begin
              phase = 0; mbusy = 0;
            end
          end
        end
      end
    endcase
    msel = (msel + int'(dir_ev) + int'(adv)) % 4;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // per-cycle comparison and pulse monitor
  initial forever begin
    @(negedge clk);
    cyc++;
    chk("step",  int'(wif.step),  int'(mstep));
    chk("start", int'(wif.start), int'(mstart));
    chk("busy",  int'(wif.busy),  int'(mbusy));
    chk("dir",   int'(wif.dir),   mdir);
    if (wif.step === 1'b1) begin
      nstep++;
      if (wif.start !== 1'b1) chk("step_gap", cyc - last_step, SD);
      last_step = cyc;
    end
    if (wif.start === 1'b1) begin
      starts.push_back(int'(wif.dir));
      start_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear();
    starts.delete(); start_cyc.delete(); nstep = 0;
  endtask

  task automatic press(bit is_dir, int hold);
    @(negedge clk);
    if (is_dir) wif.btn_dir_n = 1'b0; else wif.btn_go_n = 1'b0;
    repeat (hold) @(negedge clk);
    wif.btn_dir_n = 1'b1;
    wif.btn_go_n  = 1'b1;
    repeat (D + 1) @(negedge clk);
  endtask

  task automatic wait_idle(int maxc);
    int k = 0;
    while (wif.busy === 1'b1 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle", int'(wif.busy), 0);
  endtask

  task automatic chk_dirs(string nm, int n, int d0, int d1, int d2);
    int ex[3];
    ex = '{d0, d1, d2};
    chk({nm, "_waves"}, starts.size(), n);
    for (int i = 0; i < n && i < starts.size(); i++) chk({nm, "_dir"}, starts[i], ex[i]);
  endtask

  initial begin
    int pc, k, base;
    wif.btn_go_n = 1'b1; wif.btn_dir_n = 1'b1; wif.auto_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // idle after reset
    repeat (50) @(negedge clk);
    chk("idle_starts", starts.size(), 0);
    chk("idle_steps", nstep, 0);

    // single go press
    clear(); base = m_starts; pc = cyc;
    press(0, 10);
    wait_idle(100);
    chk_dirs("single", 1, 0, 0, 0);
    chk("single_steps", nstep, 7);
    chk("model_single", m_starts - base, 1);
    if (start_cyc.size() > 0)
      chk("go_latency_win", int'(start_cyc[0] - pc >= 7 && start_cyc[0] - pc <= 12), 1);

    // bouncing go button then held
    clear();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); wif.btn_go_n = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      @(negedge clk); wif.btn_go_n = 1'b1;
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    press(0, 10);
    wait_idle(100);
    chk_dirs("bounce", 1, 0, 0, 0);
    chk("bounce_steps", nstep, 7);

    // two dir presses, go, then a dir press mid-wave
    clear();
    press(1, 4);
    press(1, 4);
    press(0, 10);
    press(1, 4);
    wait_idle(100);
    chk_dirs("dirsel", 1, 2, 0, 0);

    // three go presses inside one wave give two back-to-back waves
    clear(); base = m_starts;
    press(0, 6);
    press(0, 4);
    press(0, 4);
    wait_idle(200);
    chk_dirs("pending", 2, 3, 3, 0);
    chk("pending_steps", nstep, 14);
    chk("model_pending", m_starts - base, 2);
    if (start_cyc.size() == 2) chk("b2b_gap", start_cyc[1] - start_cyc[0], 7 * SD);

    // auto mode for three waves, dropped mid third wave
    clear();
    @(negedge clk); wif.auto_en = 1'b1;
    k = 0;
    while (starts.size() < 3 && k < 300) begin @(negedge clk); k++; end
    repeat (8) @(negedge clk);
    wif.auto_en = 1'b0;
    wait_idle(100);
    repeat (20) @(negedge clk);
    chk_dirs("auto", 3, 3, 0, 1);
    chk("auto_steps", nstep, 21);

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          if ($urandom_range(0, 1) == 1) begin
            @(negedge clk); wif.btn_go_n = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
            @(negedge clk); wif.btn_go_n = 1'b1;
          end
          press(0, $urandom_range(2, 8));
        end
        4, 5:    press(1, $urandom_range(2, 6));
        6:       begin @(negedge clk); wif.auto_en = ($urandom_range(0, 3) == 0); end
        default: repeat ($urandom_range(1, 20)) @(negedge clk);
      endcase
    end
    @(negedge clk); wif.auto_en = 1'b0;
    repeat (10) @(negedge clk);
    wait_idle(400);

    // asynchronous reset in the middle of a wave
    press(0, 8);
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_step",  int'(wif.step),  0);
    chk("rst_start", int'(wif.start), 0);
    chk("rst_busy",  int'(wif.busy),  0);
    chk("rst_dir",   int'(wif.dir),   0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear();
    press(0, 8);
    wait_idle(100);
    chk_dirs("after_rst", 1, 0, 0, 0);
    chk("after_rst_steps", nstep, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
